// File: rtl/ghost_pkg.sv
// Shared widths, direction encoding and LFSR seed for the ghost array controller.
package ghost_pkg;

   localparam int unsigned X_W = 10;
   localparam int unsigned Y_W = 9;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Random turn: never keep the current heading.
   function automatic dir_t rand_pick(input dir_t cand, input dir_t cur);
      return (cand == cur) ? dir_t'(cand + 2'd1) : cand;
   endfunction

endpackage

// File: rtl/ghost_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting right and advancing every cycle.
module ghost_lfsr16
   import ghost_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic        fb;

   assign fb    = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
   assign state = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= {fb, state_q[15:1]};
      end
   end

endmodule

// File: rtl/ghost_array_ctrl.sv
// Array of independent ghost movers sharing one step prescaler and one LFSR.
// Define GHOST_CHASE_EN to add Pac-Man-directed turning when chase is high.
module ghost_array_ctrl
   import ghost_pkg::*;
#(
   parameter int unsigned N_GHOSTS   = 4,
   parameter int unsigned STEP_DIV   = 131072,
   parameter int unsigned START_X    = 200,
   parameter int unsigned START_Y    = 146,
   parameter int unsigned X_MAX      = 639,
   parameter int unsigned CATCH_DIST = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_GHOSTS-1:0]       blocked,
   input  logic                      chase,
   input  logic [X_W-1:0]            pac_x,
   input  logic [Y_W-1:0]            pac_y,
   output logic [X_W*N_GHOSTS-1:0]   ghost_x,
   output logic [Y_W*N_GHOSTS-1:0]   ghost_y,
   output logic [2*N_GHOSTS-1:0]     ghost_dir,
   output logic [N_GHOSTS-1:0]       turn,
   output logic                      caught
);

   localparam int unsigned CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [X_W-1:0]   X_LAST   = X_W'(X_MAX);
   localparam logic [10:0]      CATCH_L  = 11'(CATCH_DIST);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                step_tick;
   logic [15:0]         lfsr;
   logic [N_GHOSTS-1:0] near;
   logic                caught_q;
   logic                unused_lfsr;

   assign step_tick   = (cnt_q == CNT_LAST);
   assign cnt_d       = step_tick ? '0 : cnt_q + CNT_W'(1);
   assign unused_lfsr = ^lfsr;
   assign caught      = caught_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         caught_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         caught_q <= |near;
      end
   end

   ghost_lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .state (lfsr)
   );

`ifndef GHOST_CHASE_EN
   logic unused_chase;
   assign unused_chase = chase;
`endif

   for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
      logic [X_W-1:0]   x_q, x_d;
      logic [Y_W-1:0]   y_q, y_d;
      dir_t             dir_q, dir_d;
      logic             turn_q, turn_d;
      dir_t             rnd_dir, new_dir;
      logic signed [10:0] dx, dy;
      logic [10:0]      adx, ady;

      assign dx      = $signed({1'b0, pac_x}) - $signed({1'b0, x_q});
      assign dy      = $signed({2'b0, pac_y}) - $signed({2'b0, y_q});
      assign adx     = $unsigned(dx[10] ? -dx : dx);
      assign ady     = $unsigned(dy[10] ? -dy : dy);
      assign near[g] = (adx < CATCH_L) && (ady < CATCH_L);
      assign rnd_dir = rand_pick(lfsr[2*g +: 2], dir_q);

`ifdef GHOST_CHASE_EN
      dir_t chase_dir;
      logic chase_ok;

      // Close the larger axis gap first; ties favour the horizontal axis.
      always_comb begin
         chase_dir = DIR_UP;
         chase_ok  = 1'b1;
         if (adx >= ady && dx != '0) begin
            chase_dir = dx[10] ? DIR_LEFT : DIR_RIGHT;
         end else if (dy != '0) begin
            chase_dir = dy[10] ? DIR_UP : DIR_DOWN;
         end else begin
            chase_ok = 1'b0;
         end
         if (chase_dir == dir_q) begin
            chase_ok = 1'b0;
         end
      end

      assign new_dir = (chase && chase_ok) ? chase_dir : rnd_dir;
`else
      assign new_dir = rnd_dir;
`endif

      always_comb begin
         x_d    = x_q;
         y_d    = y_q;
         dir_d  = dir_q;
         turn_d = 1'b0;
         if (step_tick) begin
            if (blocked[g]) begin
               dir_d  = new_dir;
               turn_d = 1'b1;
            end else begin
               unique case (dir_q)
                  DIR_UP:    if (y_q != '0) y_d = y_q - Y_W'(1);
                  DIR_DOWN:  if (y_q != '1) y_d = y_q + Y_W'(1);
                  DIR_LEFT:  x_d = (x_q == '0) ? X_LAST : x_q - X_W'(1);
                  DIR_RIGHT: x_d = (x_q == X_LAST) ? '0 : x_q + X_W'(1);
               endcase
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            x_q    <= X_W'(START_X + 16 * g);
            y_q    <= Y_W'(START_Y);
            dir_q  <= DIR_UP;
            turn_q <= 1'b0;
         end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            dir_q  <= dir_d;
            turn_q <= turn_d;
         end
      end

      assign ghost_x[X_W*g +: X_W] = x_q;
      assign ghost_y[Y_W*g +: Y_W] = y_q;
      assign ghost_dir[2*g +: 2]   = dir_q;
      assign turn[g]               = turn_q;
   end

endmodule

// File: tb/tb_ghost_array_ctrl.sv
// Directed bench for ghost_array_ctrl with two ghosts and a 4-cycle step.
module tb_ghost_array_ctrl;

   localparam int unsigned NG = 2;
   localparam int unsigned SD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NG-1:0] blocked;
   logic          chase;
   logic [9:0]    pac_x;
   logic [8:0]    pac_y;
   logic [10*NG-1:0] ghost_x;
   logic [9*NG-1:0]  ghost_y;
   logic [2*NG-1:0]  ghost_dir;
   logic [NG-1:0]    turn;
   logic             caught;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned ph       = 0;
   logic [15:0] m_lfsr   = 16'h0000;
   logic [15:0] prev_lfsr = 16'h0000;
   logic [1:0]  cur;

   ghost_array_ctrl #(
      .N_GHOSTS (NG),
      .STEP_DIV (SD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .blocked   (blocked),
      .chase     (chase),
      .pac_x     (pac_x),
      .pac_y     (pac_y),
      .ghost_x   (ghost_x),
      .ghost_y   (ghost_y),
      .ghost_dir (ghost_dir),
      .turn      (turn),
      .caught    (caught)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock; tracks prescaler phase and a reference LFSR alongside the DUT.
   task automatic cyc();
      @(posedge clk);
      prev_lfsr = m_lfsr;
      if (rst) begin
         m_lfsr = 16'hACE1;
         ph     = 0;
      end else begin
         m_lfsr = (m_lfsr >> 1) |
                  16'((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
         ph     = (ph + 1) % SD;
      end
      #1;
   endtask

   task automatic to_tick();
      do cyc(); while (ph != 0);
   endtask

   function automatic logic [1:0] exp_rand(input logic [1:0] cand, input logic [1:0] c);
      return (cand == c) ? 2'(cand + 1) : cand;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; blocked = '0; chase = 1'b0; pac_x = '0; pac_y = '0;
      cyc(); cyc();
      rst = 1'b0;

      check_eq("rst_x0", ghost_x[9:0], 200);
      check_eq("rst_y0", ghost_y[8:0], 146);
      check_eq("rst_x1", ghost_x[19:10], 216);
      check_eq("rst_y1", ghost_y[17:9], 146);
      check_eq("rst_dir", ghost_dir, 0);
      check_eq("rst_turn", turn, 0);
      check_eq("rst_caught", caught, 0);

      // blocked toggled between ticks must be ignored
      cyc(); blocked = 2'b11; cyc(); blocked = 2'b00; cyc();
      check_eq("hold_y0", ghost_y[8:0], 146);
      to_tick();
      check_eq("tick1_x0", ghost_x[9:0], 200);
      check_eq("tick1_y0", ghost_y[8:0], 145);
      check_eq("tick1_x1", ghost_x[19:10], 216);
      check_eq("tick1_y1", ghost_y[17:9], 145);
      check_eq("tick1_turn", turn, 0);
      check_eq("tick1_dir", ghost_dir, 0);

      for (int i = 0; i < 145; i++) to_tick();
      check_eq("y0_at_top", ghost_y[8:0], 0);
      to_tick();
      check_eq("y0_sat", ghost_y[8:0], 0);
      check_eq("y1_sat", ghost_y[17:9], 0);
      check_eq("sat_x0", ghost_x[9:0], 200);

      // reset landing on a tick edge
      cyc(); cyc(); cyc();
      pac_x = 10'd205; pac_y = 9'd150;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_eq("rtick_y0", ghost_y[8:0], 146);
      check_eq("rtick_x1", ghost_x[19:10], 216);
      check_eq("rtick_y1", ghost_y[17:9], 146);
      check_eq("rtick_dir", ghost_dir, 0);
      check_eq("rtick_caught", caught, 0);

      cyc();
      check_eq("caught_near", caught, 1);
      pac_x = 10'd208; pac_y = 9'd146;
      cyc();
      check_eq("caught_edge8", caught, 0);
      pac_x = 10'd207;
      cyc();
      check_eq("caught_edge7", caught, 1);

      // first tick: LFSR candidate for ghost 0 is 0, equal to heading -> down
      pac_x = '0; pac_y = '0; blocked = 2'b01;
      to_tick();
      check_eq("turn_dir0", ghost_dir[1:0], 1);
      check_eq("turn_pulse", turn, 2'b01);
      check_eq("turn_x0", ghost_x[9:0], 200);
      check_eq("turn_y0", ghost_y[8:0], 146);
      check_eq("turn_y1", ghost_y[17:9], 145);
      cyc();
      check_eq("turn_clear", turn, 0);

      cur = 2'd1;
      for (int k = 0; k < 40 && cur != 2'd2; k++) begin
         to_tick();
         cur = exp_rand(prev_lfsr[1:0], cur);
         check_eq("rand_dir0", ghost_dir[1:0], cur);
         check_eq("rand_turn0", turn[0], 1);
      end
      check_eq("reach_left", cur, 2);
      blocked = 2'b00;
      for (int i = 0; i < 200; i++) to_tick();
      check_eq("left_x0", ghost_x[9:0], 0);
      to_tick();
      check_eq("wrap_left", ghost_x[9:0], 639);
      check_eq("wrap_left_y", ghost_y[8:0], 146);

      blocked = 2'b01;
      for (int k = 0; k < 40 && cur != 2'd3; k++) begin
         to_tick();
         cur = exp_rand(prev_lfsr[1:0], cur);
         check_eq("rand_dir0b", ghost_dir[1:0], cur);
      end
      check_eq("reach_right", cur, 3);
      blocked = 2'b00;
      to_tick();
      check_eq("wrap_right", ghost_x[9:0], 0);

      // chase steering (ignored unless the chase feature is built in)
      rst = 1'b1; cyc(); rst = 1'b0;
      pac_x = 10'd300; pac_y = 9'd150; chase = 1'b1; blocked = 2'b01;
      to_tick();
`ifdef GHOST_CHASE_EN
      cur = 2'd3;
`else
      cur = 2'd1;
`endif
      check_eq("chase_right", ghost_dir[1:0], cur);
      pac_x = 10'd202; pac_y = 9'd100;
      to_tick();
`ifdef GHOST_CHASE_EN
      cur = 2'd0;
`else
      cur = exp_rand(prev_lfsr[1:0], cur);
`endif
      check_eq("chase_up", ghost_dir[1:0], cur);
      check_eq("chase_turn", turn[0], 1);
      // chase target equals heading (or chase absent): random fallback
      to_tick();
`ifdef GHOST_CHASE_EN
      cur = exp_rand(prev_lfsr[1:0], cur);
`else
      cur = exp_rand(prev_lfsr[1:0], cur);
`endif
      check_eq("chase_fallback", ghost_dir[1:0], cur);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
